// File: rtl/fx3_stream_ctrl.sv
// FX3 GPIF burst read controller.
// Arbitrates bursts with the FX3 (dataAvailable/readData), pops BURST_WORDS samples from a
// show-ahead FIFO, widens them onto the FX3 bus, and keeps a sticky buffer-error flag.
// testMode substitutes an internal counter pattern for FIFO data.
// Optional feature macro: BURST_HEADER_EN puts a {4'hA, seq} header word at the start of
// each burst.
module fx3_stream_ctrl #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned SAMPLE_WIDTH = 10,
  parameter int unsigned LEVEL_WIDTH  = 15,
  parameter int unsigned BURST_WORDS  = 8192,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    nReset,
  input  logic                    collectData,
  input  logic                    readData,
  input  logic                    testMode,
  input  logic [LEVEL_WIDTH-1:0]  fifoLevel,
  input  logic                    fifoEmpty,
  input  logic [SAMPLE_WIDTH-1:0] fifoData,
  input  logic                    fifoOverflow,
  output logic                    fifoRead,
  output logic [DATA_WIDTH-1:0]   dataOut,
  output logic                    dataAvailable,
  output logic                    isReading,
  output logic                    bufferError
);

  localparam int unsigned WordW = $clog2(BURST_WORDS);
  // LAT counts 0 .. READ_LATENCY-2; keep at least one bit even when LAT is unused.
  localparam int unsigned LatW  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [LatW-1:0]  LatLast  = LatW'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);
  localparam logic [WordW-1:0] WordLast = WordW'(BURST_WORDS - 1);
`ifdef BURST_HEADER_EN
  localparam int unsigned NeedWords = BURST_WORDS - 1;
`else
  localparam int unsigned NeedWords = BURST_WORDS;
`endif
  localparam logic [LEVEL_WIDTH-1:0] LevelNeed = LEVEL_WIDTH'(NeedWords);

  typedef enum logic [2:0] {StIdle, StWaitData, StReady, StLat, StBurst} state_e;

  state_e                  state_q, state_d;
  logic                    rd_prev_q;
  logic [LatW-1:0]         lat_q, lat_d;
  logic [WordW-1:0]        word_q, word_d;
  logic [SAMPLE_WIDTH-1:0] pat_q, pat_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    avail_q, avail_d;
  logic                    err_q, err_d;
  logic                    burst;
  logic                    hdr;
`ifdef BURST_HEADER_EN
  logic [DATA_WIDTH-5:0]   seq_q, seq_d;
`endif

  // Burst FSM: next state plus latency and word counters.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (collectData) state_d = StWaitData;
      end
      StWaitData: begin
        if (testMode || (fifoLevel >= LevelNeed)) state_d = StReady;
      end
      StReady: begin
        // Rising edge only: a readData left high from before must drop and rise again.
        if (readData && !rd_prev_q) begin
          lat_d   = '0;
          word_d  = '0;
          state_d = (READ_LATENCY > 1) ? StLat : StBurst;
        end
      end
      StLat: begin
        if (lat_q == LatLast) state_d = StBurst;
        else                  lat_d   = lat_q + 1'b1;
      end
      StBurst: begin
        if (word_q == WordLast) state_d = StWaitData;
        else                    word_d  = word_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (!collectData) state_d = StIdle;
  end

  // Datapath: word select, pattern counter, sticky error and burst sequence number.
  always_comb begin
    burst  = (state_q == StBurst);
`ifdef BURST_HEADER_EN
    hdr    = burst && (word_q == '0);
    seq_d  = seq_q;
`else
    hdr    = 1'b0;
`endif
    data_d = data_q;
    pat_d  = pat_q;
    err_d  = err_q;
    if (burst) begin
      if (hdr) begin
`ifdef BURST_HEADER_EN
        data_d = {4'hA, seq_q};
`endif
      end else if (testMode) begin
        data_d = DATA_WIDTH'(pat_q);
        pat_d  = pat_q + 1'b1;
      end else if (fifoEmpty) begin
        data_d = '0;
        err_d  = 1'b1;
      end else begin
        data_d = DATA_WIDTH'(fifoData);
      end
    end
`ifdef BURST_HEADER_EN
    if (burst && (word_q == WordLast)) seq_d = seq_q + 1'b1;
`endif
    if ((state_q != StIdle) && fifoOverflow) err_d = 1'b1;
    // Entering or sitting in IDLE wipes per-session state.
    if (state_d == StIdle) begin
      err_d = 1'b0;
      pat_d = '0;
`ifdef BURST_HEADER_EN
      seq_d = '0;
`endif
    end
    avail_d = (state_d == StReady);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= StIdle;
      rd_prev_q <= 1'b0;
      lat_q     <= '0;
      word_q    <= '0;
      pat_q     <= '0;
      data_q    <= '0;
      avail_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef BURST_HEADER_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_prev_q <= readData;
      lat_q     <= lat_d;
      word_q    <= word_d;
      pat_q     <= pat_d;
      data_q    <= data_d;
      avail_q   <= avail_d;
      err_q     <= err_d;
`ifdef BURST_HEADER_EN
      seq_q     <= seq_d;
`endif
    end
  end

  assign fifoRead      = burst && !hdr && !testMode && !fifoEmpty;
  assign isReading     = burst;
  assign dataOut       = data_q;
  assign dataAvailable = avail_q;
  assign bufferError   = err_q;

endmodule

// File: tb/tb_fx3_stream_ctrl.sv
// Scoreboard bench for fx3_stream_ctrl (BURST_WORDS=4, READ_LATENCY=2).
// Stimulus pushes expected words and status checks; a negedge monitor pops and compares.
module tb_fx3_stream_ctrl;
  localparam int DW = 16;
  localparam int SW = 10;
  localparam int LW = 15;
  localparam int BW = 4;
  localparam int RL = 2;

  localparam int SelDataOut = 0;
  localparam int SelAvail   = 1;
  localparam int SelReading = 2;
  localparam int SelError   = 3;
  localparam int SelRead    = 4;
  localparam int SelPops    = 5;
  localparam int SelReadCyc = 6;
  localparam int SelSbLeft  = 7;
  localparam int SelClr     = 8;

  logic          clock = 1'b0;
  logic          nReset = 1'b0;
  logic          collectData = 1'b0;
  logic          readData = 1'b0;
  logic          testMode = 1'b0;
  logic [LW-1:0] fifoLevel = '0;
  logic          fifoEmpty;
  logic [SW-1:0] fifoData;
  logic          fifoOverflow = 1'b0;
  logic          fifoRead;
  logic [DW-1:0] dataOut;
  logic          dataAvailable;
  logic          isReading;
  logic          bufferError;

  fx3_stream_ctrl #(
    .DATA_WIDTH  (DW),
    .SAMPLE_WIDTH(SW),
    .LEVEL_WIDTH (LW),
    .BURST_WORDS (BW),
    .READ_LATENCY(RL)
  ) dut (
    .clock        (clock),
    .nReset       (nReset),
    .collectData  (collectData),
    .readData     (readData),
    .testMode     (testMode),
    .fifoLevel    (fifoLevel),
    .fifoEmpty    (fifoEmpty),
    .fifoData     (fifoData),
    .fifoOverflow (fifoOverflow),
    .fifoRead     (fifoRead),
    .dataOut      (dataOut),
    .dataAvailable(dataAvailable),
    .isReading    (isReading),
    .bufferError  (bufferError)
  );

  always #5 clock = ~clock;

  // Show-ahead FIFO model; force_empty injects an underflow.
  logic [SW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          force_empty = 1'b0;
  assign fifoData  = mem[rd_ptr[5:0]];
  assign fifoEmpty = force_empty || (rd_ptr == wr_ptr);
  always @(posedge clock) if (fifoRead) rd_ptr <= rd_ptr + 1;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic [DW-1:0] exp_q [$];
  chk_t          chk_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pops = 0;
  int            n_read_cyc = 0;
  logic          prev_reading = 1'b0;
  logic [DW-1:0] mon_w;
  chk_t          mon_c;
  logic [31:0]   mon_act;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SelDataOut: return 32'(dataOut);
      SelAvail:   return 32'(dataAvailable);
      SelReading: return 32'(isReading);
      SelError:   return 32'(bufferError);
      SelRead:    return 32'(fifoRead);
      SelPops:    return 32'(n_pops);
      SelReadCyc: return 32'(n_read_cyc);
      default:    return 32'(exp_q.size());
    endcase
  endfunction

  // Monitor: a word loaded after each isReading cycle, then any queued status checks.
  always @(negedge clock) begin
    if (prev_reading) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_word: dataOut=%h but no word was expected", dataOut);
      end else begin
        mon_w = exp_q.pop_front();
        if (dataOut !== mon_w) begin
          n_err++;
          $display("FAIL sb_word: dataOut=%h expected %h", dataOut, mon_w);
        end
      end
    end
    if (fifoRead) n_pops++;
    if (isReading) n_read_cyc++;
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      if (mon_c.sel == SelClr) begin
        n_pops     = 0;
        n_read_cyc = 0;
      end else begin
        mon_act = actual(mon_c.sel);
        n_cmp++;
        if (mon_act !== mon_c.exp) begin
          n_err++;
          $display("FAIL %s: got %0h expected %0h", mon_c.name, mon_act, mon_c.exp);
        end
      end
    end
    prev_reading = isReading;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_fifo(input logic [SW-1:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic expect_zero_outputs(input string tag);
    expect_sig({tag, "_dataOut"}, SelDataOut, 0);
    expect_sig({tag, "_avail"},   SelAvail,   0);
    expect_sig({tag, "_reading"}, SelReading, 0);
    expect_sig({tag, "_error"},   SelError,   0);
    expect_sig({tag, "_read"},    SelRead,    0);
  endtask

  // Bounded wait for dataAvailable; an expired bound shows up as a failed avail_pre check.
  task automatic wait_avail();
    for (int i = 0; i < 20; i++) begin
      if (dataAvailable) break;
      tick();
    end
    expect_sig("avail_pre", SelAvail, 1);
  endtask

  // One full burst; empty_cycle (1-based) forces fifoEmpty on that burst cycle, 0 for none.
  task automatic run_burst(input int empty_cycle);
    wait_avail();
    readData = 1'b1;
    tick();
    expect_sig("avail_drop", SelAvail, 0);
    tick();
    for (int k = 1; k <= BW; k++) begin
      force_empty = (k == empty_cycle);
      tick();
    end
    force_empty = 1'b0;
    readData    = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    expect_zero_outputs("rst");
    tick();
    tick();
    nReset = 1'b1;
    tick();
`ifdef BURST_HEADER_EN
    // Three header bursts with three data words each.
    for (int i = 0; i < 9; i++) push_fifo(SW'(16'h101 + i));
    for (int b = 0; b < 3; b++) begin
      exp_q.push_back(DW'(16'hA000 + b));
      for (int i = 0; i < 3; i++) exp_q.push_back(DW'(16'h101 + 3 * b + i));
    end
    fifoLevel   = LW'(3);
    collectData = 1'b1;
    expect_sig("clr", SelClr, 0);
    for (int b = 0; b < 3; b++) run_burst(0);
    expect_sig("hdr_pops", SelPops, 9);
    expect_sig("hdr_error", SelError, 0);
    collectData = 1'b0;
    tick();
`else
    // Default burst.
    push_fifo(10'h001); push_fifo(10'h002); push_fifo(10'h003); push_fifo(10'h3FF);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003); exp_q.push_back(16'h03FF);
    fifoLevel   = LW'(4);
    collectData = 1'b1;
    wait_avail();
    expect_sig("clr", SelClr, 0);
    run_burst(0);
    expect_sig("def_pops", SelPops, 4);
    expect_sig("def_reading_cycles", SelReadCyc, 4);
    expect_sig("def_hold", SelDataOut, 16'h03FF);
    expect_sig("def_error", SelError, 0);
    tick();

    // Underflow on the third burst cycle.
    push_fifo(10'h011); push_fifo(10'h022); push_fifo(10'h033);
    exp_q.push_back(16'h0011); exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0033);
    expect_sig("clr", SelClr, 0);
    run_burst(3);
    expect_sig("uf_pops", SelPops, 3);
    expect_sig("uf_error", SelError, 1);
    tick();
    tick();
    expect_sig("uf_error_held", SelError, 1);
    collectData = 1'b0;
    tick();
    expect_sig("uf_error_clear", SelError, 0);
    expect_sig("uf_idle_avail", SelAvail, 0);

    // Overflow pulse in WAIT_DATA, held through two bursts.
    fifoLevel   = '0;
    collectData = 1'b1;
    tick();
    fifoOverflow = 1'b1;
    tick();
    fifoOverflow = 1'b0;
    expect_sig("ovf_set", SelError, 1);
    for (int i = 0; i < 8; i++) begin
      push_fifo(SW'(16'h100 + i));
      exp_q.push_back(DW'(16'h100 + i));
    end
    fifoLevel = LW'(4);
    run_burst(0);
    expect_sig("ovf_hold1", SelError, 1);
    run_burst(0);
    expect_sig("ovf_hold2", SelError, 1);
    collectData = 1'b0;
    tick();
    expect_sig("ovf_clear", SelError, 0);

    // Test mode: two bursts with no FIFO data.
    fifoLevel   = '0;
    testMode    = 1'b1;
    collectData = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i));
    expect_sig("clr", SelClr, 0);
    run_burst(0);
    run_burst(0);
    expect_sig("tm_pops", SelPops, 0);
    expect_sig("tm_error", SelError, 0);
    collectData = 1'b0;
    tick();
    testMode = 1'b0;

    // Abort on the second burst cycle.
    push_fifo(10'h0A1); push_fifo(10'h0A2); push_fifo(10'h0A3); push_fifo(10'h0A4);
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2);
    fifoLevel   = LW'(4);
    collectData = 1'b1;
    wait_avail();
    expect_sig("clr", SelClr, 0);
    readData = 1'b1;
    tick();
    tick();
    tick();
    collectData = 1'b0;
    tick();
    expect_sig("abort_reading", SelReading, 0);
    expect_sig("abort_read", SelRead, 0);
    readData = 1'b0;
    tick();
    tick();
    expect_sig("abort_pops", SelPops, 2);

    // Asynchronous reset mid-LAT with non-zero dataOut and bufferError.
    fifoLevel   = '0;
    collectData = 1'b1;
    tick();
    fifoOverflow = 1'b1;
    tick();
    fifoOverflow = 1'b0;
    expect_sig("pre_rst_error", SelError, 1);
    expect_sig("pre_rst_dataOut", SelDataOut, 16'h00A2);
    fifoLevel = LW'(4);
    wait_avail();
    readData = 1'b1;
    tick();
    #2;
    nReset = 1'b0;
    #1;
    expect_zero_outputs("async_rst");
    tick();
    readData    = 1'b0;
    collectData = 1'b0;
    nReset      = 1'b1;
    tick();
    expect_zero_outputs("post_rst");
`endif
    tick();
    expect_sig("sb_left", SelSbLeft, 0);
    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/fx3_stream_ctrl.md
Name: fx3_stream_ctrl

Overview:
- Parametrised successor to the fixed 16-bit, 8192-word FX3 GPIF read state machine.
- Runs entirely in the FX3 clock domain and sits between the read side of the sample FIFO and the FX3 GPIF pins.
- Arbitrates bursts with the FX3 (dataAvailable / readData), pops a configurable number of words, and widens samples to the bus width.
- Also owns the sticky buffer-error flag and an internal test-pattern source.

Parameters:
- DATA_WIDTH, 16: FX3 data bus width. Legal range is SAMPLE_WIDTH to 32.
- SAMPLE_WIDTH, 10: FIFO word (ADC sample) width.
- LEVEL_WIDTH, 15: width of the FIFO fill-level input.
- BURST_WORDS, 8192: words transferred per FX3 burst. Must be at least 2.
- READ_LATENCY, 2: cycles from the readData sample to the first valid dataOut word. Must be at least 1.

Ports:
- clock, input, 1: FX3 clock. Every register is clocked on the rising edge.
- nReset, input, 1: asynchronous active-low reset.
- collectData, input, 1: FX3 capture enable.
- readData, input, 1: FX3 signals it is sampling the bus.
- testMode, input, 1: 1 selects the internal counter pattern instead of FIFO data.
- fifoLevel, input, LEVEL_WIDTH: words currently held in the FIFO.
- fifoEmpty, input, 1: FIFO empty flag.
- fifoData, input, SAMPLE_WIDTH: show-ahead FIFO head word.
- fifoOverflow, input, 1: single-cycle pulse on a FIFO write overflow.
- fifoRead, output, 1: pop strobe (combinational).
- dataOut, output, DATA_WIDTH: registered FX3 data bus.
- dataAvailable, output, 1: a full burst is ready.
- isReading, output, 1: a burst is in progress.
- bufferError, output, 1: sticky error flag.

Behaviour:
- Reset (nReset=0, asynchronous): state=IDLE. dataOut, dataAvailable, isReading, bufferError, the pattern counter and the word counter all go to 0. fifoRead=0.
- IDLE: leaves for WAIT_DATA when collectData=1. Entering IDLE clears bufferError and the pattern counter.
- WAIT_DATA: goes to READY when fifoLevel >= BURST_WORDS, or unconditionally when testMode=1.
- READY: dataAvailable=1.
  - A readData rising edge (previous sample 0, current sample 1) moves to LAT.
  - On that same edge dataAvailable drops to 0.
  - If readData is still high on entry to READY, the block waits for it to go low and then high again.
- LAT: lasts READ_LATENCY-1 cycles (zero cycles when READ_LATENCY=1), then moves to BURST.
- BURST: lasts exactly BURST_WORDS cycles, counted by a word counter, then returns to WAIT_DATA. isReading=1 for the whole state.
  - Timing: the first word is valid on dataOut at the clock edge READ_LATENCY edges after the edge that sampled readData=1. Each following word appears one cycle later.
- fifoRead = (state==BURST) && !testMode && !fifoEmpty.
- dataOut load in BURST, selected in this order:
  - testMode=1: load the zero-extended pattern counter, then increment the counter modulo 2^SAMPLE_WIDTH.
  - Otherwise, if fifoEmpty: load 0 and set bufferError (underflow).
  - Otherwise: load fifoData zero-extended to DATA_WIDTH.
- dataOut holds its last value outside BURST.
- The pattern counter persists across bursts and clears only in IDLE or on reset.
- collectData=0 in any state goes to IDLE on the next edge. fifoRead and isReading drop in that same edge's cycle, no further pops occur, and the partial burst is abandoned.
- fifoOverflow=1 in any state other than IDLE sets bufferError. bufferError stays set until IDLE or reset.
- An overflow and an underflow in the same cycle set the flag once; no other effect.
- testMode changing during BURST takes effect on the next word.

Optional Feature:
- Macro: BURST_HEADER_EN.
- With the macro defined:
  - The first BURST word is a header {4'hA, seq}, where seq is a burst sequence number DATA_WIDTH-4 bits wide.
  - No FIFO pop occurs on the header cycle.
  - The remaining BURST_WORDS-1 cycles pop data, and WAIT_DATA requires fifoLevel >= BURST_WORDS-1.
  - seq increments when each burst completes, wraps modulo 2^(DATA_WIDTH-4), and clears in IDLE and on reset.
- Without the macro: no header, and all BURST_WORDS cycles carry data.

Test Plan:
- Default run (BURST_WORDS=4, READ_LATENCY=2, testMode=0):
  - Stimulus: collectData=1, fifoLevel=4, FIFO holds 0x001, 0x002, 0x003, 0x3FF; readData rises at edge T.
  - Required: dataAvailable=1 before T and 0 after T. dataOut = 0x0001, 0x0002, 0x0003, 0x03FF at edges T+2 to T+5. Exactly 4 fifoRead cycles. isReading high for those 4 cycles.
- Underflow:
  - Stimulus: same setup, but fifoEmpty=1 on the 3rd burst cycle.
  - Required: dataOut=0x0000 for that word, bufferError=1 and held; after collectData goes 0, bufferError=0.
- Overflow:
  - Stimulus: a fifoOverflow pulse in WAIT_DATA.
  - Required: bufferError=1 on the next edge and held through two full bursts.
- Test mode:
  - Stimulus: testMode=1, fifoLevel=0, two bursts.
  - Required: dataAvailable asserts with no FIFO data; dataOut = 0,1,2,3 then 4,5,6,7; fifoRead never 1.
- Abort and reset:
  - Stimulus: collectData drops on the 2nd BURST cycle; later, nReset pulses low mid-LAT.
  - Required: for the abort, isReading=0 and no further pops. For the reset, all outputs are 0 immediately, asynchronously, without waiting for a clock edge.
- Header (BURST_HEADER_EN defined, BURST_WORDS=4):
  - Stimulus: three bursts, each with fifoLevel=3 available.
  - Required: first words are 0xA000, 0xA001, 0xA002; 3 pops per burst.
